// File: rtl/onehot_dec_pkg.sv
// Shared types and decode helper for the registered one-hot decoder.
package onehot_dec_pkg;

  // Widest one-hot vector the helper function can build.
  localparam int unsigned MAX_OUT_W = 64;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SCAN  = 2'b01,
    MODE_PULSE = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  typedef enum logic {
    PS_IDLE   = 1'b0,
    PS_ACTIVE = 1'b1
  } pulse_state_t;

  // Sets bit `value` when value < out_w; out-of-range codes give all zeros.
  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned value,
                                                  input int unsigned out_w);
    logic [MAX_OUT_W-1:0] r;
    r = '0;
    if (value < out_w && value < MAX_OUT_W)
      r = {{(MAX_OUT_W-1){1'b0}}, 1'b1} << value;
    return r;
  endfunction

endpackage

// File: rtl/onehot_dec_core.sv
// Combinational binary-to-one-hot decode with an in-range flag.
module onehot_dec_core
  import onehot_dec_pkg::*;
#(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  value,
  output logic [OUT_W-1:0] dec,
  output logic             valid
);

  // Decode the value and flag codes that have no output line.
  always_comb begin
    dec   = OUT_W'(onehot(32'(value), OUT_W));
    valid = (32'(value) < OUT_W);
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with HOLD, SCAN and PULSE modes.
module onehot_decoder_seq
  import onehot_dec_pkg::*;
#(
  parameter int unsigned IN_W      = 3,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  sel,
  input  logic             load,
  output logic [OUT_W-1:0] out,
  output logic             busy,
  output logic             err
);

  localparam int unsigned       TIMER_W    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(PULSE_LEN - 1);
  localparam logic [IN_W-1:0]    CNT_LAST   = IN_W'(OUT_W - 1);

  mode_t              mode_e;
  pulse_state_t       state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [IN_W-1:0]    cnt_q, cnt_d;
  logic [IN_W-1:0]    dec_value;
  logic [OUT_W-1:0]   dec;
  logic               dec_valid;
  logic [OUT_W-1:0]   out_d;
  logic               err_d;

  assign mode_e = mode_t'(mode);

  // One shared decoder: SCAN walks the counter, every other mode decodes sel.
  assign dec_value = (mode_e == MODE_SCAN) ? cnt_q : sel;

  onehot_dec_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .value (dec_value),
    .dec   (dec),
    .valid (dec_valid)
  );

  assign busy = (state_q == PS_ACTIVE);

  // Pulse FSM state and timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PS_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Pulse FSM next state: leaving PULSE or dropping enable aborts a pulse.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (!enable || mode_e != MODE_PULSE) begin
      state_d = PS_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        PS_IDLE: begin
          if (load && dec_valid) begin
            state_d = PS_ACTIVE;
            timer_d = TIMER_INIT;
          end
        end
        PS_ACTIVE: begin
          if (timer_q == '0) state_d = PS_IDLE;
          else               timer_d = timer_q - TIMER_W'(1);
        end
      endcase
    end
  end

  // Next out/err for every mode; enable low forces both to zero.
  always_comb begin
    out_d = '0;
    err_d = 1'b0;
    if (enable) begin
      case (mode_e)
        MODE_HOLD: begin
          out_d = dec;
          err_d = ~dec_valid;
        end
        MODE_SCAN: out_d = dec;
        MODE_PULSE: begin
          case (state_q)
            PS_IDLE: begin
              if (load) begin
                if (dec_valid) out_d = dec;
                else           err_d = 1'b1;
              end
            end
            PS_ACTIVE: begin
              if (timer_q != '0) out_d = out;
            end
          endcase
        end
        MODE_RSVD: err_d = 1'b1;
      endcase
    end
  end

  // Scan counter: cleared outside SCAN, held while disabled, wraps at OUT_W-1.
  always_comb begin
    cnt_d = cnt_q;
    if (mode_e != MODE_SCAN) cnt_d = '0;
    else if (enable)         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + IN_W'(1);
  end

  // Output flops and scan counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      err   <= 1'b0;
      cnt_q <= '0;
    end else begin
      out   <= out_d;
      err   <= err_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench: two decoder configurations driven by shared stimulus.
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] sel = 4'd0;
  logic       load = 1'b0;

  logic [7:0] out_a;
  logic       busy_a, err_a;
  logic [5:0] out_b;
  logic       busy_b, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.IN_W(4), .OUT_W(8), .PULSE_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel),
    .load(load), .out(out_a), .busy(busy_a), .err(err_a)
  );

  onehot_decoder_seq #(.IN_W(3), .OUT_W(6), .PULSE_LEN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel[2:0]),
    .load(load), .out(out_b), .busy(busy_b), .err(err_b)
  );

  // Behavioural model: scan position, remaining pulse cycles, lit bit (-1 none).
  typedef struct {
    int pos;
    int remain;
    int obit;
    bit err;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mreset();
    mstate_t r;
    r.pos = 0; r.remain = 0; r.obit = -1; r.err = 1'b0;
    return r;
  endfunction

  function automatic mstate_t mstep(mstate_t m, int ow, int pl, bit en, int md, int s, bit ld);
    mstate_t n;
    n = m;
    n.err = 1'b0;
    if (md != 1)  n.pos = 0;
    else if (en)  n.pos = (m.pos + 1) % ow;
    if (!en) begin
      n.obit = -1;
      n.remain = 0;
      return n;
    end
    if (md != 2) n.remain = 0;
    case (md)
      0: begin n.obit = (s < ow) ? s : -1; n.err = (s >= ow); end
      1: n.obit = m.pos;
      2: begin
        if (m.remain > 0) begin
          n.remain = m.remain - 1;
          n.obit = (n.remain > 0) ? m.obit : -1;
        end else if (ld && s < ow) begin
          n.remain = pl;
          n.obit = s;
        end else begin
          n.obit = -1;
          n.err = ld && (s >= ow);
        end
      end
      default: begin n.obit = -1; n.err = 1'b1; end
    endcase
    return n;
  endfunction

  function automatic logic [31:0] ohv(int b);
    if (b < 0) return '0;
    return 32'd1 << b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_out",  32'(out_a),  ohv(ma.obit));
    check("a_busy", 32'(busy_a), 32'(ma.remain > 0));
    check("a_err",  32'(err_a),  32'(ma.err));
    check("b_out",  32'(out_b),  ohv(mb.obit));
    check("b_busy", 32'(busy_b), 32'(mb.remain > 0));
    check("b_err",  32'(err_b),  32'(mb.err));
  endtask

  task automatic cycle();
    @(posedge clk);
    ma = mstep(ma, 8, 4, enable, int'(mode), int'(sel), load);
    mb = mstep(mb, 6, 2, enable, int'(mode), int'(sel[2:0]), load);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    ma = mreset();
    mb = mreset();
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  int scan_exp[8] = '{0, 1, 2, 3, 4, 5, 0, 1};

  initial begin
    ma = mreset();
    mb = mreset();
    #2;
    do_reset();
    check("rst_out_a", 32'(out_a), 32'h0);

    // HOLD decode, then disable
    enable = 1'b1; mode = 2'b00; sel = 4'd5;
    cycle();
    check("a_hold5", 32'(out_a), 32'h20);
    enable = 1'b0;
    cycle();
    check("a_dis", 32'(out_a), 32'h0);

    // Invalid code on the 6-output instance
    enable = 1'b1; sel = 4'd7;
    cycle();
    check("b_inv_out", 32'(out_b), 32'h0);
    check("b_inv_err", 32'(err_b), 32'h1);
    sel = 4'd2;
    cycle();
    check("b_sel2", 32'(out_b), 32'h04);
    check("b_sel2_err", 32'(err_b), 32'h0);

    // SCAN wrap, pause, resume, re-entry
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("b_scan", 32'(out_b), 32'd1 << scan_exp[i]);
    end
    enable = 1'b0;
    cycle();
    check("b_scan_dis", 32'(out_b), 32'h0);
    enable = 1'b1;
    cycle();
    check("b_scan_resume", 32'(out_b), 32'h04);
    mode = 2'b00;
    cycle();
    mode = 2'b01;
    cycle();
    check("b_scan_restart", 32'(out_b), 32'h01);

    // PULSE timing with loads held during and after the pulse
    mode = 2'b10; sel = 4'd3; load = 1'b1;
    cycle();
    check("a_pulse_start", 32'(out_a), 32'h08);
    sel = 4'd6;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("a_pulse_hold", 32'(out_a), 32'h08);
      check("a_pulse_busy", 32'(busy_a), 32'h1);
    end
    cycle();
    check("a_pulse_end", 32'(out_a), 32'h0);
    check("a_pulse_end_busy", 32'(busy_a), 32'h0);
    cycle();
    check("a_pulse_new", 32'(out_a), 32'h40);
    load = 1'b0;
    repeat (5) cycle();

    // PULSE abort by enable, then invalid load
    sel = 4'd3; load = 1'b1;
    cycle();
    load = 1'b0;
    cycle();
    enable = 1'b0;
    cycle();
    check("a_abort_out", 32'(out_a), 32'h0);
    check("a_abort_busy", 32'(busy_a), 32'h0);
    enable = 1'b1;
    cycle();
    sel = 4'd9; load = 1'b1;
    cycle();
    check("a_inv_err", 32'(err_a), 32'h1);
    check("a_inv_busy", 32'(busy_a), 32'h0);
    load = 1'b0;
    cycle();
    check("a_inv_err_clr", 32'(err_a), 32'h0);

    // Reserved mode
    mode = 2'b11;
    cycle();
    check("a_rsvd_err", 32'(err_a), 32'h1);
    check("a_rsvd_out", 32'(out_a), 32'h0);

    // Reset during an active pulse
    mode = 2'b10; sel = 4'd2; load = 1'b1;
    cycle();
    load = 1'b0;
    cycle();
    do_reset();
    check("a_rst_busy", 32'(busy_a), 32'h0);
    sel = 4'd4; load = 1'b1;
    cycle();
    check("a_after_rst", 32'(out_a), 32'h10);
    check("a_after_rst_busy", 32'(busy_a), 32'h1);
    load = 1'b0;

    // Randomised traffic
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 7) != 0);
      sel    = 4'($urandom_range(0, 15));
      load   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) do_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
